// File: rtl/add_arb_pkg.sv
// Shared constants and state encoding for the two-requester adder arbiter.
package add_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 32;

    // Result slot occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/fulladder32.sv
// 32-bit ripple-carry adder built from a chain of single-bit full adders.
module fulladder32
    import add_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic carry;

    // Ripple the carry from bit 0 upward
    always_comb begin
        sum   = '0;
        carry = cin;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder between two requesters,
// with a single registered result slot and per-requester saved carries.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int unsigned RR_INIT = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b_i,
    input  logic [NUM_REQ-1:0]              req_carry_i,
    input  logic [NUM_REQ-1:0]              req_chain_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic                            rsp_id_o,
    output logic [DATA_W-1:0]               rsp_sum_o,
    output logic                            rsp_carry_o
);

    state_t              state;
    state_t              state_nxt;
    logic                ptr;
    logic [NUM_REQ-1:0]  saved_carry;
    logic                slot_free;
    logic                gnt_id;
    logic                accept;
    logic                add_cin;
    logic [DATA_W-1:0]   add_sum;
    logic                add_cout;

    assign rsp_valid_o = (state == FULL);

    // Shared adder, operands muxed from the granted requester
    fulladder32 u_adder (
        .a    (req_a_i[gnt_id]),
        .b    (req_b_i[gnt_id]),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant selection, handshake and next-state logic
    always_comb begin
        state_nxt   = state;
        req_ready_o = '0;
        gnt_id      = ptr;
        accept      = 1'b0;
        slot_free   = !rsp_valid_o || rsp_ready_i;

        unique case (req_valid_i)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            default: gnt_id = ptr;
        endcase

        if (!rst_i && slot_free && (req_valid_i != '0)) begin
            req_ready_o[gnt_id] = 1'b1;
            accept              = 1'b1;
        end

        add_cin = req_chain_i[gnt_id] ? saved_carry[gnt_id] : req_carry_i[gnt_id];

        unique case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (rsp_ready_i && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Result slot, saved carries and priority pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_sum_o   <= '0;
            rsp_carry_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            saved_carry <= '0;
            ptr         <= 1'(RR_INIT);
        end else if (accept) begin
            rsp_sum_o           <= add_sum;
            rsp_carry_o         <= add_cout;
            rsp_id_o            <= gnt_id;
            saved_carry[gnt_id] <= add_cout;
            ptr                 <= ~gnt_id;
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: stimulus pushes expected results,
// a monitor pops and compares whatever the result slot presents.
module tb_add_arbiter;

    localparam int unsigned RR = 0;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [1:0]        req_valid_i = '0;
    logic [1:0]        req_ready_o;
    logic [1:0][31:0]  req_a_i = '0;
    logic [1:0][31:0]  req_b_i = '0;
    logic [1:0]        req_carry_i = '0;
    logic [1:0]        req_chain_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic              rsp_id_o;
    logic [31:0]       rsp_sum_o;
    logic              rsp_carry_o;

    int total = 0;
    int bad   = 0;

    // Expected results: {id, carry, sum}
    logic [33:0] q[$];
    logic        m_ptr = 1'(RR);
    logic [1:0]  m_saved = 2'b00;

    always #5 clk = ~clk;

    add_arbiter #(.RR_INIT(RR)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_carry_i (req_carry_i),
        .req_chain_i (req_chain_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_sum_o   (rsp_sum_o),
        .rsp_carry_o (rsp_carry_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model decides grant and result
    task automatic cycle(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input logic [1:0] c, input logic [1:0] ch, input logic rdy);
        logic [1:0]  exp_rdy;
        logic        g;
        logic        cin;
        logic [32:0] r;
        logic [31:0] oa;
        logic [31:0] ob;
        @(posedge clk);
        #1;
        req_valid_i = v;
        req_a_i[0]  = a0;
        req_b_i[0]  = b0;
        req_a_i[1]  = a1;
        req_b_i[1]  = b1;
        req_carry_i = c;
        req_chain_i = ch;
        rsp_ready_i = rdy;
        @(negedge clk);
        #1;
        // After the monitor's pop, an empty queue means the slot is free
        exp_rdy = 2'b00;
        g = 1'b0;
        if (!rst_i && q.size() == 0 && v != 2'b00) begin
            if (v == 2'b01)      g = 1'b0;
            else if (v == 2'b10) g = 1'b1;
            else                 g = m_ptr;
            exp_rdy[g] = 1'b1;
        end
        chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        if (exp_rdy != 2'b00) begin
            cin = ch[g] ? m_saved[g] : c[g];
            oa  = g ? a1 : a0;
            ob  = g ? b1 : b0;
            r   = 33'(oa) + 33'(ob) + 33'(cin);
            q.push_back({g, r});
            m_saved[g] = r[32];
            m_ptr      = ~g;
        end
    endtask

    task automatic idle();
        cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1);
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] s, input logic cy, input logic id);
        chk({name, "_valid"}, 64'(rsp_valid_o), 64'(1));
        chk({name, "_rsp"}, 64'({rsp_id_o, rsp_carry_o, rsp_sum_o}), 64'({id, cy, s}));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        req_valid_i = 2'b11;
        #1;
        chk("rst_valid", 64'(rsp_valid_o), 64'(0));
        chk("rst_data", 64'({rsp_id_o, rsp_carry_o, rsp_sum_o}), 64'(0));
        chk("rst_ready", 64'(req_ready_o), 64'(0));
        q.delete();
        m_saved = 2'b00;
        m_ptr   = 1'(RR);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        req_valid_i = 2'b00;
    endtask

    // Monitor: compare the presented result against the queue head
    initial begin
        forever begin
            @(negedge clk);
            chk("rsp_valid", 64'(rsp_valid_o), 64'(q.size() != 0));
            if (q.size() != 0) begin
                if (rsp_valid_o)
                    chk("rsp_data", 64'({rsp_id_o, rsp_carry_o, rsp_sum_o}), 64'(q[0]));
                if (rsp_ready_i)
                    void'(q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra0, rb0, ra1, rb1;
        // Initial reset state
        #12;
        chk("init_valid", 64'(rsp_valid_o), 64'(0));
        chk("init_data", 64'({rsp_id_o, rsp_carry_o, rsp_sum_o}), 64'(0));
        chk("init_ready", 64'(req_ready_o), 64'(0));
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Single add
        cycle(2'b01, 32'h1, 32'h2, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1);
        idle();
        expect_rsp("single", 32'h3, 1'b0, 1'b0);

        // Wrap then chain on requester 1
        cycle(2'b10, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 2'b00, 2'b00, 1'b1);
        idle();
        expect_rsp("wrap", 32'h0, 1'b1, 1'b1);
        cycle(2'b10, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b10, 1'b1);
        idle();
        expect_rsp("chain", 32'h1, 1'b0, 1'b1);

        // Contention, full throughput
        for (int i = 0; i < 8; i++)
            cycle(2'b11, $urandom, $urandom, $urandom, $urandom, 2'($urandom), 2'b00, 1'b1);

        // Backpressure: stall five cycles, then pop with same-cycle accept
        for (int i = 0; i < 5; i++)
            cycle(2'b11, $urandom, $urandom, $urandom, $urandom, 2'b00, 2'b00, 1'b0);
        cycle(2'b11, 32'h10, 32'h20, 32'h30, 32'h40, 2'b00, 2'b00, 1'b1);
        idle();

        // Reset while holding a result
        cycle(2'b01, 32'h5, 32'h6, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
        do_reset();

        // Carry isolation between requesters
        cycle(2'b01, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1);
        cycle(2'b10, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b10, 1'b1);
        idle();
        expect_rsp("isolate", 32'h0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            ra0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb0 = ($urandom_range(0, 7) == 0) ? 32'h1 : $urandom;
            ra1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb1 = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            cycle(2'($urandom), ra0, rb0, ra1, rb1, 2'($urandom), 2'($urandom),
                  1'($urandom_range(0, 3) != 0));
            if (i == 700)
                do_reset();
        end

        for (int i = 0; i < 3; i++)
            idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter RR_INIT, default 0, meaning the requester index holding priority after reset.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid_i, input, [1:0], per-requester request valid.
REQ-005 SHALL have port req_ready_o, output, [1:0], per-requester request accepted this cycle.
REQ-006 SHALL have port req_a_i, input, [1:0][31:0], per-requester operand A.
REQ-007 SHALL have port req_b_i, input, [1:0][31:0], per-requester operand B.
REQ-008 SHALL have port req_carry_i, input, [1:0], per-requester explicit carry-in.
REQ-009 SHALL have port req_chain_i, input, [1:0], 1 = use that requester's saved carry instead of req_carry_i.
REQ-010 SHALL have port rsp_valid_o, output, 1, result register holds a valid result.
REQ-011 SHALL have port rsp_ready_i, input, 1, consumer accepts the result.
REQ-012 SHALL have port rsp_id_o, output, 1, index of the requester owning the result.
REQ-013 SHALL have port rsp_sum_o, output, [31:0], registered 32-bit sum.
REQ-014 SHALL have port rsp_carry_o, output, 1, registered carry-out.

Function
REQ-015 SHALL share one 32-bit ripple adder between both requesters; one operation per accepted request.
REQ-016 Handshake: request k transfers when req_valid_i[k] && req_ready_o[k]; response transfers when rsp_valid_o && rsp_ready_i.
REQ-017 Slot free = !rsp_valid_o || rsp_ready_i; req_ready_o[k] SHALL be 1 only for the granted requester and only when slot free; never both bits set.
REQ-018 req_ready_o SHALL be combinational from req_valid_i, priority pointer and slot state, and SHALL not depend on operand values.
REQ-019 Grant: if only one requester valid, it wins; if both valid, priority pointer wins.
REQ-020 Priority pointer SHALL move to the other requester after each accepted request; unchanged when nothing accepted.
REQ-021 Carry-in = saved_carry[k] when req_chain_i[k]=1, else req_carry_i[k].
REQ-022 Latency: a request accepted in cycle N SHALL present rsp_valid_o=1 with sum, carry, id in cycle N+1.
REQ-023 Simultaneous response pop and new accept in one cycle SHALL load the new result with rsp_valid_o staying 1 (full throughput, one op/cycle).
REQ-024 Pop with no accept SHALL clear rsp_valid_o next cycle; rsp_* data hold while rsp_valid_o=1 and rsp_ready_i=0.
REQ-025 saved_carry[k] SHALL update to the adder carry-out on every accepted request of k, chained or not; the other requester's saved carry is unchanged.
REQ-026 Sum and carry SHALL be exact: {rsp_carry_o, rsp_sum_o} = A + B + carry-in, 33-bit, wrap at 2^32 with carry set.
REQ-027 States: EMPTY (rsp_valid_o=0) and FULL (rsp_valid_o=1); EMPTY->FULL on accept; FULL->EMPTY on pop without accept; FULL->FULL on accept or stall.

Reset
REQ-028 On rst_i=1 (any cycle, asynchronously) rsp_valid_o=0, rsp_sum_o=0, rsp_carry_o=0, rsp_id_o=0, saved_carry=2'b00, pointer=RR_INIT.
REQ-029 Reset mid-operation SHALL discard any held result; req_ready_o SHALL be 0 while rst_i=1.
REQ-030 First accept after reset release SHALL behave as from EMPTY.

Structure
REQ-031 Shared package add_arb_pkg SHALL hold NUM_REQ=2, DATA_W=32 and the EMPTY/FULL state enum.
REQ-032 Adder SHALL be one instance of the existing fulladder32 sub-module; no other arithmetic instances.

Verification
REQ-033 Single add: req0 A=0x0000_0001, B=0x0000_0002, carry 0, chain 0 -> next cycle rsp sum=0x0000_0003, carry 0, id 0.
REQ-034 Wrap: req1 A=0xFFFF_FFFF, B=0x0000_0001 -> sum=0x0000_0000, carry 1; then req1 chain=1, A=B=0 -> sum=0x0000_0001, carry 0.
REQ-035 Contention: both valid every cycle, rsp_ready_i=1, RR_INIT=0 -> grants 0,1,0,1, one result per cycle, ids alternate.
REQ-036 Backpressure: rsp_ready_i=0 with FULL -> req_ready_o=2'b00, rsp_* held 5 cycles; rsp_ready_i=1 -> pop and same-cycle accept.
REQ-037 Carry isolation: req0 produces carry 1, req1 chain=1 with A=B=0 -> sum=0 (req1 saved carry 0).
REQ-038 Reset while FULL -> rsp_valid_o=0 immediately, saved carries 0, pointer=RR_INIT after release.
